biquad_coeff_bank: RTL

BIQUAD_COEFF_BANK -- requirements
Module: biquad_coeff_bank

---
 rtl/biquad_coeff_bank.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/biquad_coeff_bank.sv
// Double-buffered biquad coefficient bank.
// Writes land in a shadow copy; a commit request arms the bank, and the next
// frame strobe copies every dirty channel's shadow into the active copy at once.
//
// Handshake: a request (wr_i or rd_i) is held until ack_o. It is accepted on a
// clock edge where ack_o is low; writes are also held off while busy_o is high.
// ack_o is high for exactly the cycle after acceptance, and dat_o is valid then.
module biquad_coeff_bank #(
   parameter  int NCH    = 4,
   parameter  int NCOEFF = 8,
   parameter  int CBITS  = 18,
   parameter  int CFRAC  = 14,
   localparam int AW     = $clog2(NCH) + $clog2(NCOEFF) + 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          wr_i,
   input  logic                          rd_i,
   input  logic [AW-1:0]                 adr_i,
   input  logic [31:0]                   dat_i,
   output logic [31:0]                   dat_o,
   output logic                          ack_o,
   input  logic                          update_i,
   input  logic                          frame_i,
   output logic [NCH*NCOEFF*CBITS-1:0]   coeff_o,
   output logic [NCH-1:0]                load_o,
   output logic [NCH-1:0]                dirty_o,
   output logic                          busy_o
);

   localparam int IW  = $clog2(NCOEFF);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CBITS-1:0] UNITY = {{(CBITS-1){1'b0}}, 1'b1} << CFRAC;

   typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;

   state_t state, state_n;

   logic [CBITS-1:0] shadow [NCH][NCOEFF];
   logic [CBITS-1:0] active [NCH][NCOEFF];

   logic [AW-2:0] low_bits;
   logic [AW-2:0] ch_full;
   logic [CHW-1:0] ch_sel;
   logic [IW-1:0] idx_sel;
   logic is_ctrl_space, is_ctrl, ch_ok;
   logic acc_wr, acc_rd, coef_wr, ctrl_commit, commit_req, any_dirty;
   logic update_q;
   logic [31:0] rd_val;
   logic unused_bits;

   // Address decode: MSB clear is coefficient space {ch,idx}, MSB set is control.
   assign low_bits      = adr_i[AW-2:0];
   assign ch_full       = low_bits >> IW;
   assign ch_sel        = ch_full[CHW-1:0];
   assign idx_sel       = adr_i[IW-1:0];
   assign is_ctrl_space = adr_i[AW-1];
   assign is_ctrl       = is_ctrl_space && (low_bits == '0);
   assign ch_ok         = !is_ctrl_space && (ch_full < (AW-1)'(NCH));

   assign busy_o      = (state != IDLE);
   assign acc_wr      = wr_i && !ack_o && !busy_o;
   assign acc_rd      = rd_i && !wr_i && !ack_o;
   assign coef_wr     = acc_wr && ch_ok;
   assign ctrl_commit = acc_wr && is_ctrl && dat_i[0];
   // A held update_i only counts on its rising edge.
   assign commit_req  = (update_i && !update_q) || ctrl_commit;
   // A write accepted this cycle counts as dirty for arming.
   assign any_dirty   = (|dirty_o) || coef_wr;
   assign unused_bits = ^dat_i;

   // Read mux: status word, sign-extended shadow coefficient, or zero.
   always_comb begin
      rd_val = '0;
      if (is_ctrl) begin
         rd_val[16]      = busy_o;
         rd_val[NCH-1:0] = dirty_o;
      end else if (ch_ok) begin
         rd_val = 32'($signed(shadow[ch_sel][idx_sel]));
      end
   end

   // Commit FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_n;
   end

   // Commit FSM next state: arm on request with something dirty, commit on frame.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (commit_req && any_dirty) state_n = ARMED;
         ARMED:   if (frame_i) state_n = COMMIT;
         COMMIT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Bus acknowledge, read data and update_i edge history.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_o    <= 1'b0;
         dat_o    <= '0;
         update_q <= 1'b0;
      end else begin
         ack_o    <= acc_wr || acc_rd;
         dat_o    <= acc_rd ? rd_val : '0;
         update_q <= update_i;
      end
   end

   // Shadow/active storage, dirty tracking and the per-channel load pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         load_o  <= '0;
         dirty_o <= '0;
         for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < NCOEFF; k++) begin
               shadow[c][k] <= (k == 0) ? UNITY : '0;
               active[c][k] <= (k == 0) ? UNITY : '0;
            end
         end
      end else begin
         load_o <= '0;
         if (state == COMMIT) begin
            load_o  <= dirty_o;
            dirty_o <= '0;
            for (int c = 0; c < NCH; c++) begin
               if (dirty_o[c]) active[c] <= shadow[c];
            end
         end
         if (coef_wr) begin
            shadow[ch_sel][idx_sel] <= dat_i[CBITS-1:0];
            dirty_o[ch_sel]         <= 1'b1;
         end
      end
   end

   // Flatten the active bank onto coeff_o.
   for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
      for (genvar gk = 0; gk < NCOEFF; gk++) begin : g_k
         assign coeff_o[(gc*NCOEFF+gk)*CBITS +: CBITS] = active[gc][gk];
      end
   end

endmodule
